// File: rtl/casc_counter_reg.sv
// Cascaded '163-style counter state register with carry-chained slices,
// registered wrap pulse, saturating wrap counter and optional one-shot stop.
module casc_counter_reg #(
    parameter int unsigned STAGES  = 2,
    parameter int unsigned STAGE_W = 4,
    parameter int unsigned ONESHOT = 0,
    parameter int unsigned WRAP_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_n,
    input  logic                        ld_n,
    input  logic                        enp,
    input  logic                        ent,
    input  logic [STAGES*STAGE_W-1:0]   d,
    output logic [STAGES*STAGE_W-1:0]   q,
    output logic                        rco,
    output logic                        tc_pulse,
    output logic [WRAP_W-1:0]           wraps,
    output logic                        stopped
);

    localparam int unsigned CNT_W = STAGES * STAGE_W;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_q;
    logic [CNT_W-1:0]    w_q_nxt;
    logic [CNT_W-1:0]    w_q_inc;
    logic [STAGES:0]     w_carry;
    logic                r_tc;
    logic [WRAP_W-1:0]   r_wraps;
    logic [WRAP_W-1:0]   w_wraps_nxt;
    logic                w_run;
    logic                w_cnt;
    logic                w_wrap;

    assign w_run      = (r_state == ST_RUN);
    assign w_cnt      = clr_n & ld_n & enp & ent & w_run;
    assign w_carry[0] = w_cnt;

    // Each slice advances only when every lower slice is all-ones (same edge).
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        assign w_carry[k+1] = w_carry[k] & (&r_q[k*STAGE_W +: STAGE_W]);
        assign w_q_inc[k*STAGE_W +: STAGE_W] =
            r_q[k*STAGE_W +: STAGE_W] + STAGE_W'(w_carry[k]);
    end

    // A wrap is a counting cycle out of the all-ones value.
    assign w_wrap = w_carry[STAGES];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: clear/load always restart, wrap stops in one-shot mode
    always_comb begin
        w_state_nxt = r_state;
        if (!clr_n || !ld_n) begin
            w_state_nxt = ST_RUN;
        end else if (w_wrap && (ONESHOT != 0)) begin
            w_state_nxt = ST_STOPPED;
        end
    end

    // Datapath next values, priority clr > ld > count > hold
    always_comb begin
        w_q_nxt     = w_q_inc;
        w_wraps_nxt = r_wraps;
        if (!clr_n) begin
            w_q_nxt     = '0;
            w_wraps_nxt = '0;
        end else if (!ld_n) begin
            w_q_nxt = d;
        end else if (w_wrap && (r_wraps != WRAP_MAX)) begin
            w_wraps_nxt = r_wraps + WRAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_tc    <= 1'b0;
            r_wraps <= '0;
        end else begin
            r_q     <= w_q_nxt;
            r_tc    <= w_wrap;
            r_wraps <= w_wraps_nxt;
        end
    end

    assign q        = r_q;
    assign rco      = ent & (&r_q);
    assign tc_pulse = r_tc;
    assign wraps    = r_wraps;
    assign stopped  = (r_state == ST_STOPPED);

endmodule
